// File: rtl/can_clic_seq_if.sv
// Claim/configuration bundle between interrupt sources, the core and can_clic_seq.
// The master side drives requests and claims; the slave side is the arbiter.
interface can_clic_seq_if #(
    parameter int NR_SOURCES    = 16,
    parameter int NR_PRIO_BITS  = 3,
    localparam int NR_INDEX_BITS = $clog2(NR_SOURCES)
);
    logic [NR_SOURCES-1:0]              set_i;
    logic [NR_SOURCES-1:0]              enable_i;
    logic [NR_SOURCES*NR_PRIO_BITS-1:0] prio_i;
    logic [NR_PRIO_BITS-1:0]            threshold_i;
    logic                               irq_valid_o;
    logic [NR_INDEX_BITS-1:0]           irq_index_o;
    logic [NR_PRIO_BITS-1:0]            irq_prio_o;
    logic                               irq_ready_i;
    logic [NR_SOURCES-1:0]              pending_o;
    logic                               busy_o;

    modport master (
        output set_i, enable_i, prio_i, threshold_i, irq_ready_i,
        input  irq_valid_o, irq_index_o, irq_prio_o, pending_o, busy_o
    );

    modport slave (
        input  set_i, enable_i, prio_i, threshold_i, irq_ready_i,
        output irq_valid_o, irq_index_o, irq_prio_o, pending_o, busy_o
    );
endinterface

// File: rtl/can_clic_seq.sv
// Bit-serial CAN-style interrupt arbiter: latches pend requests, resolves the winner
// one bit per cycle (priority MSB first, then index MSB first) and offers it for claim.
//
// state    | meaning
// IDLE     | waiting for an enabled pending source; snapshots inputs on start
// ARB_PRIO | eliminating contenders on one priority bit per cycle
// ARB_IDX  | eliminating contenders on one index bit per cycle, then threshold test
// OFFER    | winner presented on irq_*_o until the core claims it
module can_clic_seq #(
    parameter int NR_SOURCES    = 16,
    parameter int NR_PRIO_BITS  = 3,
    localparam int NR_INDEX_BITS = $clog2(NR_SOURCES)
) (
    input  logic clk,
    input  logic rst_n,
    can_clic_seq_if.slave bus
);
    localparam int MAX_BITS = (NR_PRIO_BITS > NR_INDEX_BITS) ? NR_PRIO_BITS : NR_INDEX_BITS;
    localparam int CNT_W    = $clog2(MAX_BITS + 1);

    typedef enum logic [1:0] {IDLE, ARB_PRIO, ARB_IDX, OFFER} state_t;

    state_t                             r_state;
    logic [NR_SOURCES-1:0]              r_pending;
    logic [NR_SOURCES-1:0]              r_cont;
    logic [NR_SOURCES*NR_PRIO_BITS-1:0] r_prio_snap;
    logic [NR_PRIO_BITS-1:0]            r_thr;
    logic [CNT_W-1:0]                   r_cnt;
    logic                               r_valid;
    logic [NR_INDEX_BITS-1:0]           r_index;
    logic [NR_PRIO_BITS-1:0]            r_prio;

    logic [NR_SOURCES-1:0]              w_mask;
    logic [NR_SOURCES-1:0]              w_hit;
    logic [NR_SOURCES-1:0]              w_next_cont;
    logic [NR_SOURCES-1:0]              w_clr;
    logic [NR_PRIO_BITS-1:0]            w_psh;
    logic [NR_INDEX_BITS-1:0]           w_ish;
    logic [NR_INDEX_BITS-1:0]           w_win_idx;
    logic [NR_PRIO_BITS-1:0]            w_win_prio;

    always_comb begin
        w_mask     = '0;
        w_psh      = '0;
        w_ish      = '0;
        w_win_idx  = '0;
        w_win_prio = '0;
        w_clr      = '0;
        for (int i = 0; i < NR_SOURCES; i++) begin
            w_psh = r_prio_snap[i*NR_PRIO_BITS +: NR_PRIO_BITS] >> r_cnt;
            w_ish = NR_INDEX_BITS'(i) >> r_cnt;
            w_mask[i] = (r_state == ARB_PRIO) ? w_psh[0] : w_ish[0];
        end
        // A bit that nobody in the field has set eliminates nobody.
        w_hit       = r_cont & w_mask;
        w_next_cont = (|w_hit) ? w_hit : r_cont;
        for (int i = 0; i < NR_SOURCES; i++) begin
            if (w_next_cont[i]) begin
                w_win_idx  = NR_INDEX_BITS'(i);
                w_win_prio = r_prio_snap[i*NR_PRIO_BITS +: NR_PRIO_BITS];
            end
            w_clr[i] = r_valid & bus.irq_ready_i & (r_index == NR_INDEX_BITS'(i)) & ~bus.set_i[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pending   <= '0;
            r_cont      <= '0;
            r_prio_snap <= '0;
            r_thr       <= '0;
            r_cnt       <= '0;
            r_valid     <= 1'b0;
            r_index     <= '0;
            r_prio      <= '0;
        end else begin
            r_pending <= (r_pending | bus.set_i) & ~w_clr;
            case (r_state)
                IDLE: begin
                    if (|(r_pending & bus.enable_i)) begin
                        r_cont      <= r_pending & bus.enable_i;
                        r_prio_snap <= bus.prio_i;
                        r_thr       <= bus.threshold_i;
                        r_cnt       <= CNT_W'(NR_PRIO_BITS - 1);
                        r_state     <= ARB_PRIO;
                    end
                end
                ARB_PRIO: begin
                    r_cont <= w_next_cont;
                    if (r_cnt == '0) begin
                        r_cnt   <= CNT_W'(NR_INDEX_BITS - 1);
                        r_state <= ARB_IDX;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ARB_IDX: begin
                    r_cont <= w_next_cont;
                    if (r_cnt == '0) begin
                        if (w_win_prio > r_thr) begin
                            r_index <= w_win_idx;
                            r_prio  <= w_win_prio;
                            r_valid <= 1'b1;
                            r_state <= OFFER;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                OFFER: begin
                    if (bus.irq_ready_i) begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.irq_valid_o = r_valid;
    assign bus.irq_index_o = r_index;
    assign bus.irq_prio_o  = r_prio;
    assign bus.pending_o   = r_pending;
    assign bus.busy_o      = (r_state != IDLE);
endmodule

// File: tb/tb_can_clic_seq.sv
// Directed bench for can_clic_seq: table of single/priority/tie rounds plus
// hand-written threshold, set/claim collision, hold and reset sequences.
module tb_can_clic_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    can_clic_seq_if #(.NR_SOURCES(16), .NR_PRIO_BITS(3)) bus ();

    can_clic_seq #(.NR_SOURCES(16), .NR_PRIO_BITS(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] set;
        logic [47:0] prio;
        logic [2:0]  thr;
        int          n_exp;
        logic [3:0]  idx0;
        logic [2:0]  pr0;
        logic [3:0]  idx1;
        logic [2:0]  pr1;
    } vec_t;

    vec_t vecs[3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name, input int limit, output int cyc);
        cyc = 0;
        while (!bus.irq_valid_o && cyc < limit) begin
            tick();
            cyc++;
        end
        check({name, " valid"}, 32'(bus.irq_valid_o), 32'd1);
    endtask

    task automatic claim(input string name);
        bus.irq_ready_i = 1'b1;
        tick();
        bus.irq_ready_i = 1'b0;
        check({name, " valid drops"}, 32'(bus.irq_valid_o), 32'd0);
    endtask

    initial begin
        int          c;
        logic [15:0] one_hot;
        bit          seen_valid, seen_b0, seen_b1, stable;

        vecs[0] = '{set: 16'h0020, prio: '0, thr: 3'd0, n_exp: 1,
                    idx0: 4'd5, pr0: 3'd3, idx1: 4'd0, pr1: 3'd0};
        vecs[0].prio[5*3 +: 3] = 3'd3;
        vecs[1] = '{set: 16'h0204, prio: '0, thr: 3'd0, n_exp: 2,
                    idx0: 4'd2, pr0: 3'd6, idx1: 4'd9, pr1: 3'd4};
        vecs[1].prio[2*3 +: 3] = 3'd6;
        vecs[1].prio[9*3 +: 3] = 3'd4;
        vecs[2] = '{set: 16'h1008, prio: '0, thr: 3'd0, n_exp: 2,
                    idx0: 4'd12, pr0: 3'd5, idx1: 4'd3, pr1: 3'd5};
        vecs[2].prio[3*3 +: 3]  = 3'd5;
        vecs[2].prio[12*3 +: 3] = 3'd5;

        // Reset must win even over active pend pulses.
        bus.set_i       = '1;
        bus.enable_i    = '1;
        bus.prio_i      = '1;
        bus.threshold_i = '0;
        bus.irq_ready_i = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst valid",   32'(bus.irq_valid_o), 32'd0);
        check("rst index",   32'(bus.irq_index_o), 32'd0);
        check("rst prio",    32'(bus.irq_prio_o),  32'd0);
        check("rst pending", 32'(bus.pending_o),   32'd0);
        check("rst busy",    32'(bus.busy_o),      32'd0);
        bus.set_i = '0;
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 3; v++) begin
            bus.enable_i    = '1;
            bus.prio_i      = vecs[v].prio;
            bus.threshold_i = vecs[v].thr;
            bus.set_i       = vecs[v].set;
            tick();
            bus.set_i = '0;
            check($sformatf("v%0d pending t+1", v), 32'(bus.pending_o), 32'(vecs[v].set));
            wait_valid($sformatf("v%0d first", v), 40, c);
            check($sformatf("v%0d latency", v), 32'(c + 1), 32'd9);
            check($sformatf("v%0d index0", v), 32'(bus.irq_index_o), 32'(vecs[v].idx0));
            check($sformatf("v%0d prio0", v),  32'(bus.irq_prio_o),  32'(vecs[v].pr0));
            claim($sformatf("v%0d claim0", v));
            one_hot = 16'h1 << vecs[v].idx0;
            check($sformatf("v%0d pending after claim0", v), 32'(bus.pending_o),
                  32'(vecs[v].set & ~one_hot));
            if (vecs[v].n_exp == 2) begin
                wait_valid($sformatf("v%0d second", v), 40, c);
                check($sformatf("v%0d index1", v), 32'(bus.irq_index_o), 32'(vecs[v].idx1));
                check($sformatf("v%0d prio1", v),  32'(bus.irq_prio_o),  32'(vecs[v].pr1));
                claim($sformatf("v%0d claim1", v));
                check($sformatf("v%0d pending empty", v), 32'(bus.pending_o), 32'd0);
            end
            tick();
        end

        // Threshold: prio equal to threshold never wins, rounds keep restarting.
        bus.prio_i = '0;
        bus.prio_i[7*3 +: 3] = 3'd2;
        bus.threshold_i = 3'd2;
        bus.set_i = 16'h0080;
        tick();
        bus.set_i = '0;
        seen_valid = 1'b0; seen_b0 = 1'b0; seen_b1 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.irq_valid_o) seen_valid = 1'b1;
            if (bus.busy_o) seen_b1 = 1'b1; else seen_b0 = 1'b1;
        end
        check("thr no valid",     32'(seen_valid), 32'd0);
        check("thr pending kept", 32'(bus.pending_o), 32'h0080);
        check("thr busy cycles",  32'({seen_b0, seen_b1}), 32'd3);
        bus.threshold_i = 3'd1;
        wait_valid("thr lowered", 20, c);
        check("thr index", 32'(bus.irq_index_o), 32'd7);
        check("thr prio",  32'(bus.irq_prio_o),  32'd2);
        claim("thr claim");
        bus.threshold_i = 3'd0;
        tick();

        // Set of the same source in its claim cycle keeps it pending.
        bus.prio_i = '0;
        bus.prio_i[4*3 +: 3] = 3'd3;
        bus.set_i = 16'h0010;
        tick();
        bus.set_i = '0;
        wait_valid("col first", 20, c);
        check("col index", 32'(bus.irq_index_o), 32'd4);
        bus.set_i = 16'h0010;
        bus.irq_ready_i = 1'b1;
        tick();
        bus.set_i = '0;
        bus.irq_ready_i = 1'b0;
        check("col valid drops", 32'(bus.irq_valid_o), 32'd0);
        check("col pending kept", 32'(bus.pending_o), 32'h0010);
        wait_valid("col again", 20, c);
        check("col index again", 32'(bus.irq_index_o), 32'd4);
        claim("col claim");
        check("col pending clear", 32'(bus.pending_o), 32'd0);
        tick();

        // Hold: offer stays put while ready is low and inputs move underneath.
        bus.prio_i = '0;
        bus.prio_i[1*3 +: 3] = 3'd7;
        bus.set_i = 16'h0002;
        tick();
        bus.set_i = '0;
        wait_valid("hold first", 20, c);
        bus.enable_i = '0;
        bus.prio_i = '0;
        bus.threshold_i = 3'd7;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!(bus.irq_valid_o && bus.irq_index_o == 4'd1 && bus.irq_prio_o == 3'd7))
                stable = 1'b0;
        end
        check("hold stable", 32'(stable), 32'd1);
        claim("hold claim");
        check("hold pending clear", 32'(bus.pending_o), 32'd0);
        bus.enable_i = '1;
        bus.threshold_i = 3'd0;
        tick();

        // Reset in the middle of priority arbitration aborts the round.
        bus.prio_i = '0;
        bus.prio_i[6*3 +: 3] = 3'd5;
        bus.set_i = 16'h0040;
        tick();
        bus.set_i = '0;
        tick();
        check("rst2 busy arb", 32'(bus.busy_o), 32'd1);
        tick();
        bus.irq_ready_i = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.irq_ready_i = 1'b0;
        check("rst2 valid",   32'(bus.irq_valid_o), 32'd0);
        check("rst2 pending", 32'(bus.pending_o),   32'd0);
        check("rst2 busy",    32'(bus.busy_o),      32'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.irq_valid_o || bus.busy_o) seen_valid = 1'b1;
        end
        check("rst2 stays idle", 32'(seen_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
